// File: rtl/decode_stage.sv
// RV32I(+M) decode pipeline stage: combinational decode of the fetched word
// feeding a valid/ready output register, with load-use interlock and flush.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter bit ENABLE_M      = 1'b1,
    parameter bit ENABLE_HAZARD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_alu_op,
    output logic [1:0]      out_alu_src_a,
    output logic [1:0]      out_alu_src_b,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_jump_src,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_reg_write,
    output logic [1:0]      out_reg_write_src,
    output logic            out_illegal,
    output logic            hazard_stall
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD       = 3'b000,
        ALU_BRANCH    = 3'b001,
        ALU_ARITH     = 3'b010,
        ALU_ARITH_IMM = 3'b011,
        ALU_MULDIV    = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_ZERO = 2'b01,
        SRC_A_PC   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2 = 2'b00,
        SRC_B_IMM = 2'b01
    } src_b_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rd     = in_instr[11:7];

    logic [31:0]     imm_i;
    logic [31:0]     imm_s;
    logic [31:0]     imm_b;
    logic [31:0]     imm_u;
    logic [31:0]     imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    alu_op_e         dec_alu_op;
    src_a_e          dec_src_a;
    src_b_e          dec_src_b;
    wb_src_e         dec_wb_src;
    logic            dec_branch;
    logic            dec_jump;
    logic            dec_jump_src;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_reg_write;
    logic            dec_legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            accept;

    assign dec_imm = XLEN'($signed(dec_imm32));

    // Decode the incoming word into the control bundle and legality flag
    always_comb begin
        dec_imm32     = '0;
        dec_alu_op    = ALU_ADD;
        dec_src_a     = SRC_A_RS1;
        dec_src_b     = SRC_B_RS2;
        dec_wb_src    = WB_ALU;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_jump_src  = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_legal     = (in_instr[1:0] == 2'b11);
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_alu_op    = ALU_ARITH;
                dec_reg_write = 1'b1;
                uses_rs2      = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_alu_op = ALU_ARITH;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_alu_op = ALU_ARITH;
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    dec_alu_op = ALU_MULDIV;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_imm32     = imm_i;
                dec_alu_op    = ALU_ARITH_IMM;
                dec_src_b     = SRC_B_IMM;
                dec_reg_write = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec_legal = 1'b0;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec_legal = 1'b0;
            end
            OPC_LOAD: begin
                dec_imm32     = imm_i;
                dec_src_b     = SRC_B_IMM;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
                dec_wb_src    = WB_MEM;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    dec_legal = 1'b0;
            end
            OPC_STORE: begin
                dec_imm32     = imm_s;
                dec_src_b     = SRC_B_IMM;
                dec_mem_write = 1'b1;
                uses_rs2      = 1'b1;
                if (funct3 >= 3'b011)
                    dec_legal = 1'b0;
            end
            OPC_BRANCH: begin
                dec_imm32  = imm_b;
                dec_alu_op = ALU_BRANCH;
                dec_branch = 1'b1;
                uses_rs2   = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    dec_legal = 1'b0;
            end
            OPC_JAL: begin
                dec_imm32     = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_wb_src    = WB_PC4;
                uses_rs1      = 1'b0;
            end
            OPC_JALR: begin
                dec_imm32     = imm_i;
                dec_jump      = 1'b1;
                dec_jump_src  = 1'b1;
                dec_alu_op    = ALU_ARITH_IMM;
                dec_src_b     = SRC_B_IMM;
                dec_reg_write = 1'b1;
                dec_wb_src    = WB_PC4;
                if (funct3 != 3'b000)
                    dec_legal = 1'b0;
            end
            OPC_LUI: begin
                dec_imm32     = imm_u;
                dec_src_a     = SRC_A_ZERO;
                dec_src_b     = SRC_B_IMM;
                dec_reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                dec_imm32     = imm_u;
                dec_src_a     = SRC_A_PC;
                dec_src_b     = SRC_B_IMM;
                dec_reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase

        // Illegal words travel downstream but must not cause side effects
        if (!dec_legal) begin
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
            dec_jump_src  = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_reg_write = 1'b0;
        end
        if (rd == 5'd0)
            dec_reg_write = 1'b0;
    end

    assign hazard_stall = ENABLE_HAZARD && in_valid && out_valid && out_mem_read && (out_rd != 5'd0) &&
                          ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));
    assign in_ready     = !flush && !hazard_stall && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;

    // Output register: flush kills, accept loads, consume without accept empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_pc            <= '0;
            out_rs1           <= '0;
            out_rs2           <= '0;
            out_rd            <= '0;
            out_funct3        <= '0;
            out_funct7        <= '0;
            out_imm           <= '0;
            out_alu_op        <= '0;
            out_alu_src_a     <= '0;
            out_alu_src_b     <= '0;
            out_branch        <= 1'b0;
            out_jump          <= 1'b0;
            out_jump_src      <= 1'b0;
            out_mem_read      <= 1'b0;
            out_mem_write     <= 1'b0;
            out_reg_write     <= 1'b0;
            out_reg_write_src <= '0;
            out_illegal       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_pc            <= in_pc;
            out_rs1           <= rs1;
            out_rs2           <= rs2;
            out_rd            <= rd;
            out_funct3        <= funct3;
            out_funct7        <= funct7;
            out_imm           <= dec_imm;
            out_alu_op        <= dec_alu_op;
            out_alu_src_a     <= dec_src_a;
            out_alu_src_b     <= dec_src_b;
            out_branch        <= dec_branch;
            out_jump          <= dec_jump;
            out_jump_src      <= dec_jump_src;
            out_mem_read      <= dec_mem_read;
            out_mem_write     <= dec_mem_write;
            out_reg_write     <= dec_reg_write;
            out_reg_write_src <= dec_wb_src;
            out_illegal       <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus hand sequences for
// hazard bubble, hold, flush and asynchronous reset.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_ready;

    logic            in_ready, out_valid, hazard_stall;
    logic [XLEN-1:0] out_pc, out_imm;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [2:0]      out_funct3, out_alu_op;
    logic [6:0]      out_funct7;
    logic [1:0]      out_alu_src_a, out_alu_src_b, out_reg_write_src;
    logic            out_branch, out_jump, out_jump_src, out_mem_read, out_mem_write;
    logic            out_reg_write, out_illegal;

    logic            nm_in_ready, nm_out_valid, nm_hazard_stall;
    logic [XLEN-1:0] nm_out_pc, nm_out_imm;
    logic [4:0]      nm_out_rs1, nm_out_rs2, nm_out_rd;
    logic [2:0]      nm_out_funct3, nm_out_alu_op;
    logic [6:0]      nm_out_funct7;
    logic [1:0]      nm_out_alu_src_a, nm_out_alu_src_b, nm_out_reg_write_src;
    logic            nm_out_branch, nm_out_jump, nm_out_jump_src, nm_out_mem_read, nm_out_mem_write;
    logic            nm_out_reg_write, nm_out_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b1), .ENABLE_HAZARD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
        .out_branch(out_branch), .out_jump(out_jump), .out_jump_src(out_jump_src),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .out_reg_write_src(out_reg_write_src), .out_illegal(out_illegal), .hazard_stall(hazard_stall)
    );

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b0), .ENABLE_HAZARD(1'b1)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(nm_out_valid), .out_ready(out_ready),
        .out_pc(nm_out_pc), .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2), .out_rd(nm_out_rd),
        .out_funct3(nm_out_funct3), .out_funct7(nm_out_funct7), .out_imm(nm_out_imm),
        .out_alu_op(nm_out_alu_op), .out_alu_src_a(nm_out_alu_src_a), .out_alu_src_b(nm_out_alu_src_b),
        .out_branch(nm_out_branch), .out_jump(nm_out_jump), .out_jump_src(nm_out_jump_src),
        .out_mem_read(nm_out_mem_read), .out_mem_write(nm_out_mem_write), .out_reg_write(nm_out_reg_write),
        .out_reg_write_src(nm_out_reg_write_src), .out_illegal(nm_out_illegal), .hazard_stall(nm_hazard_stall)
    );

    always #5 clk = ~clk;

    // Control bundle packed as {alu_op, src_a, src_b, branch, jump, jump_src,
    // mem_read, mem_write, reg_write, wb_src, illegal}
    logic [15:0] act_ctl;
    assign act_ctl = {out_alu_op, out_alu_src_a, out_alu_src_b, out_branch, out_jump, out_jump_src,
                      out_mem_read, out_mem_write, out_reg_write, out_reg_write_src, out_illegal};

    typedef struct {
        logic [31:0] instr;
        logic        full;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [15:0] ctl;
        logic [15:0] mask;
    } vec_t;

    vec_t vecs[$];

    localparam logic [15:0] MASK_ALL = 16'hFFFF;
    // Only the side-effect bits and the illegal flag are defined for illegal words
    localparam logic [15:0] MASK_ILL = 16'h01B9;
    localparam logic [15:0] CTL_ILL  = 16'h0001;

    function automatic logic [15:0] ctl(input logic [2:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                                        input logic br, input logic j, input logic js, input logic mr,
                                        input logic mw, input logic rw, input logic [1:0] wb, input logic ill);
        return {alu, sa, sb, br, j, js, mr, mw, rw, wb, ill};
    endfunction

    task automatic add_vec(input logic [31:0] instr, input logic full, input logic [4:0] rd,
                           input logic [31:0] imm, input logic [15:0] c);
        vec_t v;
        v.instr = instr;
        v.full  = full;
        v.rd    = rd;
        v.imm   = imm;
        v.ctl   = c;
        v.mask  = full ? MASK_ALL : MASK_ILL;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;

        add_vec(32'h00500093, 1'b1, 5'd1,  32'h00000005, ctl(3'b011, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // addi x1,x0,5
        add_vec(32'hFFF08093, 1'b1, 5'd1,  32'hFFFFFFFF, ctl(3'b011, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // addi x1,x1,-1
        add_vec(32'h402081B3, 1'b1, 5'd3,  32'h00000000, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // sub
        add_vec(32'h0020A423, 1'b1, 5'd8,  32'h00000008, ctl(3'b000, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0, 2'b00, 0)); // sw x2,8(x1)
        add_vec(32'hFE000EE3, 1'b1, 5'd29, 32'hFFFFFFFC, ctl(3'b001, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0)); // beq -4
        add_vec(32'h008000EF, 1'b1, 5'd1,  32'h00000008, ctl(3'b000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 2'b10, 0)); // jal x1,8
        add_vec(32'h004100E7, 1'b1, 5'd1,  32'h00000004, ctl(3'b011, 2'b00, 2'b01, 0, 1, 1, 0, 0, 1, 2'b10, 0)); // jalr x1,4(x2)
        add_vec(32'h123450B7, 1'b1, 5'd1,  32'h12345000, ctl(3'b000, 2'b01, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // lui
        add_vec(32'h00001217, 1'b1, 5'd4,  32'h00001000, ctl(3'b000, 2'b10, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // auipc
        add_vec(32'h4030D093, 1'b1, 5'd1,  32'h00000403, ctl(3'b011, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 0)); // srai
        add_vec(32'h00100013, 1'b1, 5'd0,  32'h00000001, ctl(3'b011, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0)); // addi x0
        add_vec(32'h0000A103, 1'b1, 5'd2,  32'h00000000, ctl(3'b000, 2'b00, 2'b01, 0, 0, 0, 1, 0, 1, 2'b01, 0)); // lw x2,0(x1)
        add_vec(32'h0000007F, 1'b0, 5'd0,  32'h0, CTL_ILL); // unknown opcode
        add_vec(32'h40309093, 1'b0, 5'd0,  32'h0, CTL_ILL); // slli with funct7 0100000
        add_vec(32'h4020E1B3, 1'b0, 5'd0,  32'h0, CTL_ILL); // or with funct7 0100000
        add_vec(32'h0000B103, 1'b0, 5'd0,  32'h0, CTL_ILL); // load funct3 011
        add_vec(32'h0020B423, 1'b0, 5'd0,  32'h0, CTL_ILL); // store funct3 011
        add_vec(32'h00002063, 1'b0, 5'd0,  32'h0, CTL_ILL); // branch funct3 010
        add_vec(32'h000010E7, 1'b0, 5'd0,  32'h0, CTL_ILL); // jalr funct3 001
        add_vec(32'h00500090, 1'b0, 5'd0,  32'h0, CTL_ILL); // instr[1:0] != 11

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_pc", out_pc, 32'd0);
        check("rst out_imm", out_imm, 32'd0);
        check("rst ctl", 32'(act_ctl), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Table: back-to-back at one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h100 + 32'(i) * 4;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            sample();
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d out_pc", i), out_pc, 32'h100 + 32'(i) * 4);
            check($sformatf("v%0d ctl", i), 32'(act_ctl & vecs[i].mask), 32'(vecs[i].ctl & vecs[i].mask));
            if (vecs[i].full) begin
                check($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
                check($sformatf("v%0d rd", i), 32'(out_rd), 32'(vecs[i].rd));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        sample();
        check("empty out_valid", 32'(out_valid), 32'd0);

        // MUL with and without the M extension
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h027302B3; in_pc = 32'h180;
        sample();
        check("mul alu_op", 32'(out_alu_op), 32'h4);
        check("mul illegal", 32'(out_illegal), 32'd0);
        check("mul reg_write", 32'(out_reg_write), 32'd1);
        check("mul noM illegal", 32'(nm_out_illegal), 32'd1);
        check("mul noM reg_write", 32'(nm_out_reg_write), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        sample();

        // Load-use: LW x2 then ADD x3,x2,x1 gives exactly one bubble
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h0000A103; in_pc = 32'h200;
        sample();
        check("lw out_valid", 32'(out_valid), 32'd1);
        check("lw mem_read", 32'(out_mem_read), 32'd1);
        @(negedge clk);
        in_instr = 32'h001101B3; in_pc = 32'h204;
        #1;
        check("lu hazard_stall", 32'(hazard_stall), 32'd1);
        check("lu in_ready", 32'(in_ready), 32'd0);
        sample();
        check("lu bubble", 32'(out_valid), 32'd0);
        check("lu stall released", 32'(hazard_stall), 32'd0);
        sample();
        check("add out_valid", 32'(out_valid), 32'd1);
        check("add alu_op", 32'(out_alu_op), 32'h2);
        check("add out_pc", out_pc, 32'h204);
        check("add rd", 32'(out_rd), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        sample();

        // Hold with out_ready low, then flush
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
        sample();
        @(negedge clk);
        out_ready = 1'b0; in_instr = 32'h123450B7; in_pc = 32'h304;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d out_pc", c), out_pc, 32'h300);
            check($sformatf("hold%0d out_imm", c), out_imm, 32'h5);
            check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        flush = 1'b1;
        sample();
        check("flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sample();
        check("flush no capture", 32'(out_valid), 32'd0);

        // Flush beats an otherwise acceptable input
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400; flush = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        sample();
        check("flush vs accept", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset mid-operation
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h500;
        sample();
        check("pre-rst out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_imm", out_imm, 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I(+M) instruction-decode pipeline stage between fetch and execute.
- Decodes the instruction into the execute/memory/writeback control bundle and sign-extended immediate, and holds the result in an output register with a valid/ready handshake.
- Inserts a bubble on load-use hazards against the instruction it currently holds.
- Supports synchronous flush for taken branches and jumps, and flags illegal encodings.

Parameters:
- XLEN, 32, data/PC width; immediates are sign-extended to XLEN.
- ENABLE_M, 1, decode the M extension (OP, funct7=0000001) as alu_op MULDIV; when 0 these encodings are illegal.
- ENABLE_HAZARD, 1, enable the load-use interlock; when 0 there is no interlock stall.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle (combinational).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  execute consumes this cycle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode, 0 for R-type).
- out_alu_op  out  3  000 ADD-forced, 001 BRANCH, 010 ARITH, 011 ARITH_IMM, 100 MULDIV.
- out_alu_src_a  out  2  00 rs1, 01 zero, 10 PC.
- out_alu_src_b  out  2  00 rs2, 01 imm.
- out_branch, out_jump, out_jump_src  out  1 each  branch; jal/jalr; 0=jal, 1=jalr.
- out_mem_read, out_mem_write  out  1 each  load; store.
- out_reg_write  out  1  writeback enable (forced 0 when rd==0).
- out_reg_write_src  out  2  00 ALU, 01 memory, 10 PC+4.
- out_illegal  out  1  instruction is illegal.
- hazard_stall  out  1  load-use interlock active (combinational).

Behaviour:
- Reset: all out_* registers and out_valid are 0.
- Accept condition: accept = in_valid && in_ready. On accept, the decoded bundle is registered and out_valid=1 the next cycle (latency 1).
- in_ready = !flush && !hazard_stall && (!out_valid || out_ready). This gives full throughput at 1 instruction/cycle when there are no hazards.
- Hold: when out_valid && !out_ready, all out_* are stable.
- Emptying: when out_ready && !accept, out_valid goes to 0 the next cycle.
- Hazard: hazard_stall = ENABLE_HAZARD && in_valid && out_valid && out_mem_read && out_rd!=0 && (uses_rs1 && rs1==out_rd || uses_rs2 && rs2==out_rd).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - Effect: the held load drains on out_ready, then a single bubble cycle (out_valid=0) follows, then the dependent instruction is accepted.
- Flush: out_valid is 0 the next cycle and the incoming instruction is not captured. Flush wins over accept and over hazard.
- Decode per opcode:
  - OP: ARITH, rs1/rs2.
  - OP-IMM: ARITH_IMM, rs1/imm.
  - LOAD: ADD, rs1/imm, mem_read, wb src 01.
  - STORE: ADD, rs1/imm, mem_write, no reg_write.
  - BRANCH: BRANCH, rs1/rs2.
  - JAL: jump, wb src 10.
  - JALR: jump, jump_src, ARITH_IMM, rs1/imm, wb src 10.
  - LUI: ADD, zero/imm.
  - AUIPC: ADD, PC/imm.
  - reg_write is 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
- Illegal encodings:
  - instr[1:0]!=11, or unknown opcode.
  - OP with funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (ENABLE_M only)}.
  - Shift-immediate with funct7 not in {0000000, 0100000 (SRAI only)}.
  - LOAD with funct3 011/110/111.
  - STORE with funct3 >= 011.
  - BRANCH with funct3 010/011.
  - JALR with funct3 != 000.
  - An illegal instruction is still passed downstream: out_valid=1 and out_illegal=1, with branch, jump, mem_*, and reg_write all 0.
- Reset mid-operation immediately clears out_valid; in_ready then follows its equation.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 -> one cycle later out_valid=1, alu_op=011, src_b=01, imm=5, rd=1, reg_write=1.
- LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x1 (0x001101B3) -> hazard_stall=1, exactly one out_valid=0 bubble between LW and ADD, ADD carries alu_op=010.
- MUL x5,x6,x7 (0x027302B3): ENABLE_M=1 -> alu_op=100, illegal=0; ENABLE_M=0 -> illegal=1, reg_write=0.
- LUI x1,0x12345 (0x123450B7) -> imm=0x12345000, src_a=01. BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, branch=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0. Assert flush -> out_valid=0 next cycle, input not captured.
- Opcode 0x7F and ADDI with rd=0 -> illegal=1 for the first; the second gives illegal=0 and reg_write=0.
